led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//   Parametrised LED pattern generator for the board's LED bank and debug header.
//   A free-running prescaler produces a pattern tick; on each tick the LED register
//   advances according to a selectable mode: rotate left, rotate right, bounce, or binary count.
//   Sits between the board clock and LED/GPIO pins; mode, rate and enable come from
//   switches or a control register.
// PARAMETERS
//   WIDTH     8   number of LED outputs (>= 2)
//   DIV_W     27  prescaler width; also the width of div and count
// PORTS
//   clk      in   1      system clock; all logic on rising edge
//   rst_n    in   1      asynchronous active-low reset
//   enable   in   1      1 = run; 0 = freeze prescaler and pattern
//   mode     in   2      00 rot-left, 01 rot-right, 10 bounce, 11 binary count
//   div      in   DIV_W  tick period minus one (period = div+1 clk cycles)
//   led      out  WIDTH  registered pattern
//   tick     out  1      registered 1-cycle pulse; high in the cycle led shows a new value
//   count    out  DIV_W  registered prescaler value (debug/GPIO)
// BEHAVIOUR
//   Reset (rst_n=0, async): count=0, led={WIDTH-1{0},1}, dir=left, tick=0, mode_q=00.
//   mode_q is a register holding the previous mode. mode_chg = (mode != mode_q). mode_q <= mode every cycle, including when disabled.
//   Priority per rising edge, highest first:
//     1. mode_chg: led<=1, dir<=left, count<=0, tick<=0 (reseed; overrides tick and enable)
//     2. enable=0: count, led, dir hold; tick<=0
//     3. count>=div: count<=0, tick<=1, led<=next(led)
//     4. otherwise: count<=count+1, tick<=0
//   Using >= means lowering div below the current count wraps on the next edge; no long stall.
//   div=0: tick every cycle and the pattern advances every cycle.
//   next(led) per mode (DIV_W, WIDTH arithmetic is unsigned, mod 2^WIDTH):
//     00: {led[WIDTH-2:0], led[WIDTH-1]}   rotate left; bit WIDTH-1 wraps to bit 0
//     01: {led[0], led[WIDTH-1:1]}         rotate right; bit 0 wraps to bit WIDTH-1
//     10: bounce, using the single-hot pattern and dir:
//         dir=left and led[WIDTH-1]=1: dir<=right, led<=led>>1 (reverse, no dwell)
//         dir=right and led[0]=1:      dir<=left,  led<=led<<1
//         else shift one place in dir
//         Sequence period = 2*(WIDTH-1) ticks.
//     11: led+1; all-ones wraps to 0; the next tick gives 1
//   dir is only meaningful in mode 10. It is reset to left on every mode change.
//   tick and the new led value appear on the same edge: latency is 1 clk from count==div.
//   rst_n asserted mid-pattern returns all state to reset values immediately (async).
//   On release the first tick comes div+1 edges later.
//   div may change at any time; it is sampled each cycle and not latched.
// TESTING
//   T1 reset: rst_n=0 mid-run -> led=8'h01, tick=0, count=0 same cycle.
//      Release with div=3, mode=00 -> tick on 4th edge, led=8'h02.
//   T2 rot-left wrap: div=0, mode=00, 8 ticks from 8'h01 -> 02,04,..,80,01.
//      mode=01 from reseed -> 80,40,..,01.
//   T3 bounce, WIDTH=4, div=0, mode=10 -> 2,4,8,4,2,1,2,4; tick high every cycle.
//   T4 count mode: mode=11, div=1 -> led 2,3,4.. every 2nd cycle.
//      Force to FF (WIDTH=8) -> next 00, then 01.
//   T5 div shrink: div=100, wait until count=50, set div=10 -> tick next edge, count=0.
//      Then a period of 11 cycles.
//   T6 enable/mode: enable=0 for 20 cycles -> led, count frozen, tick=0.
//      Mode change during enable=0 -> led=01, count=0. A mode change on the tick edge -> reseed wins, tick=0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a free-running prescaler produces a pattern tick, and
// each tick advances the LED register by rotate-left, rotate-right, bounce or
// binary count. A mode change reseeds the pattern and restarts the prescaler.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic [DIV_W-1:0] count
);

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

  dir_t             dir, dir_d, dir_adv;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] led_d, led_adv;
  logic [DIV_W-1:0] count_d;
  logic             tick_d;
  logic             mode_chg;

  assign mode_chg = (mode != mode_q);

  // Pattern step: what led/dir become if this edge is a tick.
  always_comb begin
    led_adv = led;
    dir_adv = dir;
    case (mode)
      2'b00: led_adv = {led[WIDTH-2:0], led[WIDTH-1]};
      2'b01: led_adv = {led[0], led[WIDTH-1:1]};
      2'b10: begin
        // Reverse at the ends without dwelling on the end LED.
        if (dir == DIR_LEFT && led[WIDTH-1]) begin
          dir_adv = DIR_RIGHT;
          led_adv = led >> 1;
        end else if (dir == DIR_RIGHT && led[0]) begin
          dir_adv = DIR_LEFT;
          led_adv = led << 1;
        end else if (dir == DIR_LEFT) begin
          led_adv = led << 1;
        end else begin
          led_adv = led >> 1;
        end
      end
      default: led_adv = led + WIDTH'(1);
    endcase
  end

  // Next state: reseed on mode change beats freeze, which beats the tick.
  always_comb begin
    led_d   = led;
    dir_d   = dir;
    count_d = count;
    tick_d  = 1'b0;
    if (mode_chg) begin
      led_d   = SEED;
      dir_d   = DIR_LEFT;
      count_d = '0;
    end else if (!enable) begin
      // hold everything, tick stays low
    end else if (count >= div) begin
      // >= so a div lowered below count wraps on the next edge
      count_d = '0;
      tick_d  = 1'b1;
      led_d   = led_adv;
      dir_d   = dir_adv;
    end else begin
      count_d = count + DIV_W'(1);
    end
  end

  // State registers; mode_q tracks mode every cycle, even when frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= SEED;
      dir    <= DIR_LEFT;
      count  <= '0;
      tick   <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      led    <= led_d;
      dir    <= dir_d;
      count  <= count_d;
      tick   <= tick_d;
      mode_q <= mode;
    end
  end

endmodule
